// File: rtl/if_id_fetch_queue_pkg.sv
// rtl/if_id_fetch_queue_pkg.sv - shared fetch/decode types and constants
package if_id_fetch_queue_pkg;

  localparam int WORD_W = 32;
  localparam int PC_W   = 32;

  // One fetched instruction together with its word-indexed PC+1.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] inst;
  } fetch_pair_t;

  // MOV r0, r0: what downstream stages substitute while out_valid is low.
  localparam logic [WORD_W-1:0] NOP_INST = 32'hE1A0_0000;

  function automatic fetch_pair_t make_pair(input logic [PC_W-1:0] pc,
                                            input logic [WORD_W-1:0] inst);
    fetch_pair_t p;
    p.pc   = pc;
    p.inst = inst;
    return p;
  endfunction

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// rtl/if_id_fetch_queue_if.sv - fetch-side and decode-side handshake bundle
interface if_id_fetch_queue_if
  import if_id_fetch_queue_pkg::*;
#(
  parameter int PTR_W = 2
);

  logic              flush;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [WORD_W-1:0] in_inst;
  logic              in_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [WORD_W-1:0] out_inst;
  logic              out_ready;
  logic [PTR_W:0]    count;

  // Pipeline side: fetch, execute (flush) and decode.
  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  // The queue itself.
  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

endinterface

// File: rtl/if_id_fetch_queue_fifo_mem.sv
// rtl/if_id_fetch_queue_fifo_mem.sv - DEPTH-entry pair storage, one write port, async read
module fifo_mem
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  fetch_pair_t      wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output fetch_pair_t      rd_data
);

  fetch_pair_t mem [DEPTH];

  // Storage is never cleared; occupancy tracking decides what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - IF/ID decoupling FIFO with branch flush
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  if_id_fetch_queue_if.slave   q
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             push;
  logic             pop;
  fetch_pair_t      wr_pair;
  fetch_pair_t      rd_pair;

  // Ready/valid come only from registered occupancy, so a pop never frees a
  // slot for a push in the same cycle and there is no in->out bypass.
  assign q.in_ready  = (count_q != FULL_CNT);
  assign q.out_valid = (count_q != '0);
  assign q.count     = count_q;

  // A flush cancels both transfers of its cycle.
  assign push = q.in_valid & q.in_ready & ~q.flush;
  assign pop  = q.out_valid & q.out_ready & ~q.flush;

  assign wr_pair = make_pair(q.in_pc, q.in_inst);

  // Head entry is zeroed when nothing is queued so decode sees no stale data.
  assign q.out_pc   = q.out_valid ? rd_pair.pc   : '0;
  assign q.out_inst = q.out_valid ? rd_pair.inst : '0;

  fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_pair),
    .rd_addr (rd_ptr),
    .rd_data (rd_pair)
  );

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
